// File: rtl/global_timer_sync_rx.sv
// Receive side of the global timer sync link: deserialises the 35-bit broadcast
// frame, checks parity/stop, applies link and frame compensation, tracks lock.
module global_timer_sync_rx #(
    parameter int unsigned LINK_DELAY = 8,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        i_enable,
    input  logic        i_sync,
    output logic [31:0] o_value,
    output logic        o_write,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_locked
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // Cycles from start-bit sampling to the o_write cycle.
    localparam logic [31:0] FRAME_COMP  = 32'd35;
    localparam logic [15:0] LOCK_RELOAD = 16'(TIMEOUT);

    state_t      state;
    logic [31:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        par_bit;
    logic [15:0] lock_cnt;
    logic        good_frame;

    function automatic logic [31:0] compensate(input logic [31:0] d);
        return d + FRAME_COMP + 32'(LINK_DELAY);
    endfunction

    assign good_frame = (state == ST_STOP) && i_enable && i_sync &&
                        (par_bit == ^shift_reg);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            par_bit      <= 1'b0;
            o_value      <= '0;
            o_write      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_write      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            if (!i_enable) begin
                state     <= ST_IDLE;
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!i_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {shift_reg[30:0], i_sync};
                        bit_cnt   <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= i_sync;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!i_sync) begin
                            // A low stop bit means we may be mid-stream; wait for idle-high.
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end else begin
                            if (good_frame) begin
                                o_value <= compensate(shift_reg);
                                o_write <= 1'b1;
                            end else begin
                                o_parity_err <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end
                    end
                    ST_BREAK: begin
                        if (i_sync) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Lock timer: reloaded by each good frame, errors do not refresh it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lock_cnt <= '0;
            o_locked <= 1'b0;
        end else if (good_frame) begin
            lock_cnt <= LOCK_RELOAD;
            o_locked <= (LOCK_RELOAD != 16'd0);
        end else if (lock_cnt != 16'd0) begin
            lock_cnt <= lock_cnt - 16'd1;
            o_locked <= (lock_cnt != 16'd1);
        end
    end

endmodule

// File: tb/tb_global_timer_sync_rx.sv
// Randomised bench for global_timer_sync_rx: a per-cycle stimulus table is
// scanned by a frame-level reference model, then replayed and compared.
module tb_global_timer_sync_rx;

    localparam int LINK_DELAY = 8;
    localparam int TIMEOUT    = 100;
    localparam int MAXN       = 4096;

    logic        Clk;
    logic        Reset_n;
    logic        i_enable;
    logic        i_sync;
    logic [31:0] o_value;
    logic        o_write;
    logic        o_parity_err;
    logic        o_frame_err;
    logic        o_locked;

    global_timer_sync_rx #(
        .LINK_DELAY(LINK_DELAY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .i_enable    (i_enable),
        .i_sync      (i_sync),
        .o_value     (o_value),
        .o_write     (o_write),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err),
        .o_locked    (o_locked)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    bit          sync_a [MAXN];
    bit          en_a   [MAXN];
    bit          rst_a  [MAXN];
    bit          exp_wr [MAXN];
    bit          exp_pe [MAXN];
    bit          exp_fe [MAXN];
    bit          exp_lk [MAXN];
    logic [31:0] wval   [MAXN];
    logic [31:0] exp_val[MAXN];

    int wp;
    int n_tests;
    int n_fail;
    int w_a, w_b, w_c1, w_c2, w_p, w_f, w_r, w_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic put(input bit s, input bit e, input bit r);
        if (wp < MAXN) begin
            sync_a[wp] = s;
            en_a[wp]   = e;
            rst_a[wp]  = r;
            wp++;
        end
    endtask

    task automatic add_line(input bit s, input int n);
        for (int i = 0; i < n; i++) put(s, 1'b1, 1'b0);
    endtask

    task automatic add_frame(input logic [31:0] d, input bit par_flip, input bit stop);
        put(1'b0, 1'b1, 1'b0);
        for (int i = 31; i >= 0; i--) put(d[i], 1'b1, 1'b0);
        put((^d) ^ par_flip, 1'b1, 1'b0);
        put(stop, 1'b1, 1'b0);
    endtask

    // Frame-level model: locate starts, decide each frame's outcome from its bits.
    task automatic build_model(input int n);
        int pos, k, abort_at, j, lw;
        logic [31:0] d, val;
        for (int i = 0; i < n; i++) begin
            exp_wr[i] = 1'b0; exp_pe[i] = 1'b0; exp_fe[i] = 1'b0; wval[i] = '0;
        end
        pos = 0;
        while (pos < n) begin
            if (rst_a[pos] || !en_a[pos] || sync_a[pos]) begin
                pos++;
                continue;
            end
            k = pos;
            if (k + 34 >= n) break;
            abort_at = -1;
            for (int t = k; t <= k + 34; t++)
                if (abort_at < 0 && (rst_a[t] || !en_a[t])) abort_at = t;
            if (abort_at >= 0) begin
                pos = rst_a[abort_at] ? abort_at : abort_at + 1;
                continue;
            end
            d = '0;
            for (int i = 0; i < 32; i++) d = {d[30:0], sync_a[k + 1 + i]};
            if (sync_a[k + 34]) begin
                if (sync_a[k + 33] == ^d) begin
                    exp_wr[k + 34] = 1'b1;
                    wval[k + 34]   = d + 32'd35 + 32'(LINK_DELAY);
                end else begin
                    exp_pe[k + 34] = 1'b1;
                end
                pos = k + 35;
            end else begin
                exp_fe[k + 34] = 1'b1;
                j = k + 35;
                while (j < n && !rst_a[j] && en_a[j] && !sync_a[j]) j++;
                pos = (j < n && rst_a[j]) ? j : j + 1;
            end
        end
        val = '0;
        lw  = -1;
        for (int i = 0; i < n; i++) begin
            if (rst_a[i]) begin
                val = '0;
                lw  = -1;
            end else if (exp_wr[i]) begin
                val = wval[i];
                lw  = i;
            end
            exp_val[i] = val;
            exp_lk[i]  = (lw >= 0) && (i - lw < TIMEOUT);
        end
    endtask

    initial begin
        int t, sel, n;
        logic [31:0] d;
        Reset_n  = 1'b0;
        i_enable = 1'b0;
        i_sync   = 1'b1;
        wp = 0; n_tests = 0; n_fail = 0;

        put(1'b1, 1'b1, 1'b1);
        put(1'b1, 1'b1, 1'b1);
        add_line(1'b1, 3);
        w_a = wp + 34; add_frame(32'h0000_1000, 1'b0, 1'b1);
        add_line(1'b1, 5);
        w_b = wp + 34; add_frame(32'hFFFF_FFF0, 1'b0, 1'b1);
        add_line(1'b1, 3);
        w_p = wp + 34; add_frame(32'h1234_5678, 1'b1, 1'b1);
        add_line(1'b1, 2);
        w_f = wp + 34; add_frame(32'h0F0F_0F0F, 1'b0, 1'b0);
        add_line(1'b0, 10);
        add_line(1'b1, 2);
        add_frame(32'hCAFE_0001, 1'b0, 1'b1);
        add_line(1'b1, 4);
        w_c1 = wp + 34; add_frame(32'd1, 1'b0, 1'b1);
        w_c2 = wp + 34; add_frame(32'd2, 1'b0, 1'b1);
        add_line(1'b1, 150);
        t = wp; add_frame(32'hABCD_0000, 1'b0, 1'b1);
        wp = t + 20; put(1'b1, 1'b1, 1'b1);
        add_line(1'b1, 3);
        w_r = wp + 34; add_frame(32'h0000_0100, 1'b0, 1'b1);
        add_line(1'b1, 4);
        t = wp; add_frame(32'h5555_AAAA, 1'b0, 1'b1);
        wp = t + 20; put(1'b1, 1'b0, 1'b0);
        add_line(1'b1, 3);
        w_e = wp + 34; add_frame(32'h0000_0200, 1'b0, 1'b1);

        while (wp < 3500) begin
            sel = $urandom_range(0, 6);
            d   = $urandom;
            case (sel)
                0, 1: add_frame(d, 1'b0, 1'b1);
                2: add_frame(d, 1'b1, 1'b1);
                3: begin
                    add_frame(d, 1'($urandom_range(0, 1)), 1'b0);
                    add_line(1'b0, $urandom_range(0, 6));
                end
                4: begin
                    t = wp; add_frame(d, 1'b0, 1'b1);
                    wp = t + $urandom_range(1, 34); put(1'b1, 1'b0, 1'b0);
                end
                5: add_line(1'b1, $urandom_range(0, 120));
                default: begin
                    t = wp; add_frame(d, 1'b0, 1'b1);
                    wp = t + $urandom_range(1, 34); put(1'b1, 1'b1, 1'b1);
                end
            endcase
        end
        add_line(1'b1, 40);
        n = wp;
        build_model(n);

        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            Reset_n  = !rst_a[k];
            i_enable = en_a[k];
            i_sync   = sync_a[k];
            @(posedge Clk);
            #1;
            check("write",  {31'd0, o_write},      {31'd0, exp_wr[k]});
            check("perr",   {31'd0, o_parity_err}, {31'd0, exp_pe[k]});
            check("ferr",   {31'd0, o_frame_err},  {31'd0, exp_fe[k]});
            check("locked", {31'd0, o_locked},     {31'd0, exp_lk[k]});
            check("value",  o_value,               exp_val[k]);
            if (k == w_a)  check("val_102b",  o_value, 32'h0000_102B);
            if (k == w_b)  check("val_wrap",  o_value, 32'h0000_001B);
            if (k == w_p)  check("perr_val",  o_value, 32'h0000_001B);
            if (k == w_f)  check("ferr_pls",  {31'd0, o_frame_err}, 32'd1);
            if (k == w_c1) check("val_44",    o_value, 32'd44);
            if (k == w_c2) check("val_45",    o_value, 32'd45);
            if (k == w_c2 + TIMEOUT - 1) check("lock_hold", {31'd0, o_locked}, 32'd1);
            if (k == w_c2 + TIMEOUT)     check("lock_drop", {31'd0, o_locked}, 32'd0);
            if (k == w_r)  check("val_rst",   o_value, 32'h0000_0100 + 32'd43);
            if (k == w_e)  check("val_en",    o_value, 32'h0000_0200 + 32'd43);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/global_timer_sync_rx.md
# global_timer_sync_rx

Receive side of the board-level global timer distribution. Deserialises the timer broadcast frame sent by the master board over a single-wire sync link, checks it, adds the fixed link and frame compensation, and emits the corrected 32-bit value with a one-cycle write strobe. It sits directly upstream of the local global timer, whose load value and load strobe it drives. It also reports link health: parity and framing errors, and a lock indication with timeout.

## Interface
- `LINK_DELAY`, default 8: link transport delay in Clk cycles, added to every received value.
- `TIMEOUT`, default 65535: Clk cycles without a good frame before `o_locked` drops; 1..65535.
- `Clk` input 1: single clock for all logic.
- `Reset_n` input 1: asynchronous, active-low reset.
- `i_enable` input 1: receiver enable; low aborts any frame in progress and holds FSM in IDLE.
- `i_sync` input 1: serial sync line, already synchronised to Clk, idle high, one bit per Clk.
- `o_value` output 32: compensated timer value; valid while `o_write`=1, holds last good value otherwise.
- `o_write` output 1: one-cycle strobe, good frame received; feeds the timer load strobe.
- `o_parity_err` output 1: one-cycle pulse, frame dropped on parity mismatch.
- `o_frame_err` output 1: one-cycle pulse, frame dropped on bad stop bit.
- `o_locked` output 1: at least one good frame within the last TIMEOUT cycles.

## Operation
- Frame on `i_sync`, 35 bits, one per cycle: start (0), D[31:0] MSB first, even parity over D, stop (1).
- FSM states:
  - IDLE: wait for `i_sync`=0 with `i_enable`=1, then go to DATA and clear the bit counter.
  - DATA: shift in 32 bits, with a 5-bit counter 0..31. At count 31 go to PARITY.
  - PARITY: sample the parity bit, then go to STOP.
  - STOP:
    - Stop=1 and parity good: load `o_value` and pulse `o_write`, then go to IDLE.
    - Stop=1 and parity bad: pulse `o_parity_err`, then go to IDLE.
    - Stop=0: pulse `o_frame_err` and go to BREAK. This applies regardless of parity, and only one error pulse is issued.
  - BREAK: wait for `i_sync`=1, then go to IDLE. This blocks a false start inside a corrupted stream.
- `i_enable`=0 in any state: go to IDLE next cycle, discard the shift register, no pulses.
- Compensation: `o_value` = D + 35 + LINK_DELAY, modulo 2^32. The 32-bit sum wraps silently.
  - The constant 35 is the cycle count from start-bit sampling to the `o_write` cycle.
  - The result therefore equals the master's timer value in the `o_write` cycle when the master transmits its own value at start-bit time.
- Lock counter, 16 bits:
  - Reloads to TIMEOUT on each `o_write`.
  - Otherwise decrements while nonzero.
  - `o_locked` = (counter != 0).
  - Error pulses do not reload it.
- Reset (`Reset_n`=0, any time including mid-frame): FSM to IDLE, all registers cleared. All outputs go low at once: `o_value`=0, `o_write`=0, `o_parity_err`=0, `o_frame_err`=0, `o_locked`=0.

## Timing
- Start bit sampled at cycle T:
  - Data bits are sampled at T+1..T+32, parity at T+33, stop at T+34.
  - `o_write` or the error pulse is registered and visible in cycle T+35.
- All outputs are registered; no combinational path from inputs to outputs.
- Back-to-back frames: a new start bit may be sampled at T+35 (the cycle after stop), concurrently with the `o_write` pulse. Sustained rate is one frame per 35 cycles.
- `o_value` changes only in the cycle `o_write` rises.
- Lock behaviour:
  - `o_locked` rises at T+35 together with the first `o_write`.
  - It falls exactly TIMEOUT cycles after the last `o_write` if no new good frame arrives.
- Release of `Reset_n` takes effect asynchronously. The first start bit may be sampled on the first Clk edge after release.

## Test plan
- Good frame, D=0x0000_1000, LINK_DELAY=8 -> `o_write` high for exactly one cycle at T+35, `o_value`=0x0000_102B, `o_locked` rises in the same cycle.
- Wrap: D=0xFFFF_FFF0, LINK_DELAY=8 -> `o_value`=0x0000_001B, no error pulses.
- Parity bit flipped on D=0x1234_5678 -> `o_parity_err` pulse at T+35, no `o_write`, `o_value` unchanged.
- Stop bit 0, then line held low 10 cycles -> `o_frame_err` pulse at T+35, no new frame accepted until the line returns high. Next good frame is received correctly.
- Two good frames back-to-back, D=1 then D=2 -> `o_write` at T+35 and T+70 with `o_value` 44 and 45. Then no traffic with TIMEOUT=100 -> `o_locked` drops 100 cycles after the second `o_write`.
- `Reset_n` pulsed low at T+20, and in a separate run `i_enable` dropped at T+20 -> no pulses, FSM back in IDLE, a following good frame is received correctly.
